// File: rtl/control_sequencer_if.sv
// Purpose: groups the control sequencer's datapath-facing signals.
//   master : the sequencer; samples IR/Stop and drives every strobe, OP, Run, ill_op, instr_count
//   slave  : the datapath side; drives IR/Stop and observes the rest
// Ports (signals):
//   IR[31:0], Stop                        datapath -> sequencer
//   Rin[15:0], Rout[15:0]                 one-hot register load / bus-drive strobes
//   PCout PCin IncPC MARin MDRin MDRout IRin Yin Read
//   ZLowin ZHighin ZLowout ZHighout HIin LOin   single-bit strobes
//   OP[4:0]                               ALU operation select
//   Run, ill_op, instr_count[CNT_W-1:0]   status
interface control_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      IR;
    logic             Stop;
    logic [15:0]      Rin;
    logic [15:0]      Rout;
    logic             PCout;
    logic             PCin;
    logic             IncPC;
    logic             MARin;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;
    logic             Yin;
    logic             Read;
    logic             ZLowin;
    logic             ZHighin;
    logic             ZLowout;
    logic             ZHighout;
    logic             HIin;
    logic             LOin;
    logic [4:0]       OP;
    logic             Run;
    logic             ill_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  IR, Stop,
        output Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Read,
               ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, OP, Run, ill_op, instr_count
    );

    modport slave (
        output IR, Stop,
        input  Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Read,
               ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, OP, Run, ill_op, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Purpose: hardwired control unit for the single-bus datapath. Runs fetch T0-T2, decodes IR
//   and issues execute steps T3-T6 for reg-reg ALU ops, NOP and HALT.
// Ports:
//   Clock  in  system clock, all state changes on posedge
//   Clear  in  synchronous active-high reset; wins over any in-flight instruction
//   bus    control_sequencer_if.master  IR/Stop in; strobes, OP, Run, ill_op, instr_count out
// Strobes are a combinational decode of the registered state and IR so the datapath
// captures them on the following posedge.
module control_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                Clock,
    input  logic                Clear,
    control_sequencer_if.master bus
);

    localparam int unsigned OPC_W = 5;
    localparam int unsigned REG_N = 16;
    localparam int unsigned SEL_W = 4;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ILL,
        C_ALU2,
        C_MULDIV,
        C_UNARY,
        C_NOP,
        C_HALT
    } cls_t;

    state_t            state;
    state_t            state_next;
    cls_t              cls;
    logic [OPC_W-1:0]  opc;
    logic [OPC_W-1:0]  alu_op;
    logic [SEL_W-1:0]  ra;
    logic [SEL_W-1:0]  rb;
    logic [SEL_W-1:0]  rc;
    logic              retire;
    logic [CNT_W-1:0]  count;

    logic [REG_N-1:0]  rin;
    logic [REG_N-1:0]  rout;
    logic              pc_out;
    logic              pc_in;
    logic              inc_pc;
    logic              mar_in;
    logic              mdr_in;
    logic              mdr_out;
    logic              ir_in;
    logic              y_in;
    logic              read;
    logic              zlow_in;
    logic              zhigh_in;
    logic              zlow_out;
    logic              zhigh_out;
    logic              hi_in;
    logic              lo_in;
    logic [OPC_W-1:0]  op;
    logic              run;
    logic              ill;

    assign opc = bus.IR[31:27];
    assign ra  = bus.IR[26:23];
    assign rb  = bus.IR[22:19];
    assign rc  = bus.IR[18:15];

    // Instruction class and ALU select from the opcode field
    always_comb begin
        cls    = C_ILL;
        alu_op = '0;
        case (opc)
            OPC_ADD:  begin cls = C_ALU2;   alu_op = 5'b00000; end
            OPC_SUB:  begin cls = C_ALU2;   alu_op = 5'b00001; end
            OPC_AND:  begin cls = C_ALU2;   alu_op = 5'b00010; end
            OPC_OR:   begin cls = C_ALU2;   alu_op = 5'b00101; end
            OPC_MUL:  begin cls = C_MULDIV; alu_op = 5'b00110; end
            OPC_DIV:  begin cls = C_MULDIV; alu_op = 5'b00111; end
            OPC_NEG:  begin cls = C_UNARY;  alu_op = 5'b00011; end
            OPC_NOT:  begin cls = C_UNARY;  alu_op = 5'b00100; end
            OPC_NOP:  cls = C_NOP;
            OPC_HALT: cls = C_HALT;
            default:  cls = C_ILL;
        endcase
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge Clock) begin
        if (Clear) begin
            count <= '0;
        end else if (retire) begin
            count <= count + CNT_W'(1);
        end
    end

    // Next-state and strobe decode; Clear suppresses everything so nothing in flight completes
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        rin        = '0;
        rout       = '0;
        pc_out     = 1'b0;
        pc_in      = 1'b0;
        inc_pc     = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        read       = 1'b0;
        zlow_in    = 1'b0;
        zhigh_in   = 1'b0;
        zlow_out   = 1'b0;
        zhigh_out  = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        op         = '0;
        run        = 1'b0;
        ill        = 1'b0;

        if (!Clear) begin
            run = (state != S_IDLE) && (state != S_HALT);
            case (state)
                S_IDLE: state_next = S_T0;
                S_T0: begin
                    // Z <= PC + 1 while PC drives the bus into MAR
                    pc_out     = 1'b1;
                    mar_in     = 1'b1;
                    inc_pc     = 1'b1;
                    zlow_in    = 1'b1;
                    state_next = S_T1;
                end
                S_T1: begin
                    zlow_out   = 1'b1;
                    pc_in      = 1'b1;
                    read       = 1'b1;
                    mdr_in     = 1'b1;
                    state_next = S_T2;
                end
                S_T2: begin
                    mdr_out    = 1'b1;
                    ir_in      = 1'b1;
                    state_next = S_T3;
                end
                S_T3: begin
                    case (cls)
                        C_ALU2, C_MULDIV: begin
                            rout       = REG_N'(1) << rb;
                            y_in       = 1'b1;
                            state_next = S_T4;
                        end
                        C_UNARY: begin
                            rout       = REG_N'(1) << rb;
                            op         = alu_op;
                            zlow_in    = 1'b1;
                            state_next = S_T4;
                        end
                        C_HALT:  state_next = S_HALT;
                        C_NOP:   retire = 1'b1;
                        default: begin
                            ill    = 1'b1;
                            retire = 1'b1;
                        end
                    endcase
                end
                S_T4: begin
                    case (cls)
                        C_ALU2, C_MULDIV: begin
                            rout       = REG_N'(1) << rc;
                            op         = alu_op;
                            zlow_in    = 1'b1;
                            zhigh_in   = (cls == C_MULDIV);
                            state_next = S_T5;
                        end
                        default: begin
                            zlow_out = 1'b1;
                            rin      = REG_N'(1) << ra;
                            retire   = 1'b1;
                        end
                    endcase
                end
                S_T5: begin
                    zlow_out = 1'b1;
                    if (cls == C_MULDIV) begin
                        lo_in      = 1'b1;
                        state_next = S_T6;
                    end else begin
                        rin    = REG_N'(1) << ra;
                        retire = 1'b1;
                    end
                end
                S_T6: begin
                    zhigh_out = 1'b1;
                    hi_in     = 1'b1;
                    retire    = 1'b1;
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_IDLE;
            endcase

            // Stop is only honoured at an instruction boundary
            if (retire) begin
                state_next = bus.Stop ? S_HALT : S_T0;
            end
        end
    end

    assign bus.Rin         = rin;
    assign bus.Rout        = rout;
    assign bus.PCout       = pc_out;
    assign bus.PCin        = pc_in;
    assign bus.IncPC       = inc_pc;
    assign bus.MARin       = mar_in;
    assign bus.MDRin       = mdr_in;
    assign bus.MDRout      = mdr_out;
    assign bus.IRin        = ir_in;
    assign bus.Yin         = y_in;
    assign bus.Read        = read;
    assign bus.ZLowin      = zlow_in;
    assign bus.ZHighin     = zhigh_in;
    assign bus.ZLowout     = zlow_out;
    assign bus.ZHighout    = zhigh_out;
    assign bus.HIin        = hi_in;
    assign bus.LOin        = lo_in;
    assign bus.OP          = op;
    assign bus.Run         = run;
    assign bus.ill_op      = ill;
    assign bus.instr_count = count;

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: directed self-checking bench for control_sequencer; walks fetch/execute for
//   neg, add, mul, undefined, nop and halt, plus Stop and Clear interactions.
module tb_control_sequencer;

    localparam logic [14:0] M_PCOUT    = 15'h4000;
    localparam logic [14:0] M_PCIN     = 15'h2000;
    localparam logic [14:0] M_INCPC    = 15'h1000;
    localparam logic [14:0] M_MARIN    = 15'h0800;
    localparam logic [14:0] M_MDRIN    = 15'h0400;
    localparam logic [14:0] M_MDROUT   = 15'h0200;
    localparam logic [14:0] M_IRIN     = 15'h0100;
    localparam logic [14:0] M_YIN      = 15'h0080;
    localparam logic [14:0] M_READ     = 15'h0040;
    localparam logic [14:0] M_ZLOWIN   = 15'h0020;
    localparam logic [14:0] M_ZHIGHIN  = 15'h0010;
    localparam logic [14:0] M_ZLOWOUT  = 15'h0008;
    localparam logic [14:0] M_ZHIGHOUT = 15'h0004;
    localparam logic [14:0] M_HIIN     = 15'h0002;
    localparam logic [14:0] M_LOIN     = 15'h0001;

    localparam logic [31:0] I_NEG  = 32'h88080000;
    localparam logic [31:0] I_ADD  = 32'h18918000;
    localparam logic [31:0] I_MUL  = 32'h78918000;
    localparam logic [31:0] I_ILL  = 32'hF8000000;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;

    logic clk = 1'b0;
    logic clear;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    control_sequencer_if #(.CNT_W(16)) bus ();

    control_sequencer #(.CNT_W(16)) dut (
        .Clock (clk),
        .Clear (clear),
        .bus   (bus)
    );

    logic [14:0] str;
    assign str = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin,
                  bus.Yin, bus.Read, bus.ZLowin, bus.ZHighin, bus.ZLowout, bus.ZHighout,
                  bus.HIin, bus.LOin};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_step(input string tag, input logic [14:0] e_str, input logic [15:0] e_rin,
                              input logic [15:0] e_rout, input logic [4:0] e_op,
                              input logic e_run, input logic e_ill);
        check({tag, " strobes"}, 32'(str), 32'(e_str));
        check({tag, " Rin"}, 32'(bus.Rin), 32'(e_rin));
        check({tag, " Rout"}, 32'(bus.Rout), 32'(e_rout));
        check({tag, " OP"}, 32'(bus.OP), 32'(e_op));
        check({tag, " Run"}, 32'(bus.Run), 32'(e_run));
        check({tag, " ill_op"}, 32'(bus.ill_op), 32'(e_ill));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while in T0; checks T0, T1 and T2, leaving the bench in T2
    task automatic fetch(input string tag);
        check_step({tag, " T0"}, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick();
        check_step({tag, " T1"}, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick();
        check_step({tag, " T2"}, M_MDROUT | M_IRIN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
    endtask

    initial begin
        clear    = 1'b1;
        bus.IR   = '0;
        bus.Stop = 1'b0;
        tick();
        tick();
        check_step("reset", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        check("reset count", 32'(bus.instr_count), 32'd0);

        clear = 1'b0;
        #1;
        check_step("idle", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // neg R0,R1
        tick();
        bus.IR = I_NEG;
        #1;
        fetch("neg");
        tick();
        check_step("neg T3", M_ZLOWIN, 16'h0, 16'h0002, 5'b00011, 1'b1, 1'b0);
        tick();
        check_step("neg T4", M_ZLOWOUT, 16'h0001, 16'h0, 5'd0, 1'b1, 1'b0);
        check("neg count before retire", 32'(bus.instr_count), 32'd0);

        // add R1,R2,R3
        tick();
        check("neg count", 32'(bus.instr_count), 32'd1);
        bus.IR = I_ADD;
        #1;
        fetch("add");
        tick();
        check_step("add T3", M_YIN, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0);
        tick();
        check_step("add T4", M_ZLOWIN, 16'h0, 16'h0008, 5'd0, 1'b1, 1'b0);
        tick();
        check_step("add T5", M_ZLOWOUT, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b0);

        // mul R1,R2,R3
        tick();
        check("add count", 32'(bus.instr_count), 32'd2);
        bus.IR = I_MUL;
        #1;
        fetch("mul");
        tick();
        check_step("mul T3", M_YIN, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0);
        tick();
        check_step("mul T4", M_ZLOWIN | M_ZHIGHIN, 16'h0, 16'h0008, 5'b00110, 1'b1, 1'b0);
        tick();
        check_step("mul T5", M_ZLOWOUT | M_LOIN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick();
        check_step("mul T6", M_ZHIGHOUT | M_HIIN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);

        // undefined opcode
        tick();
        check("mul count", 32'(bus.instr_count), 32'd3);
        bus.IR = I_ILL;
        #1;
        fetch("ill");
        tick();
        check_step("ill T3", 15'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1);

        // add with Stop raised in T4
        tick();
        check("ill count", 32'(bus.instr_count), 32'd4);
        check("ill_op pulse ends", 32'(bus.ill_op), 32'd0);
        bus.IR = I_ADD;
        #1;
        fetch("stop add");
        tick();
        tick();
        check_step("stop add T4", M_ZLOWIN, 16'h0, 16'h0008, 5'd0, 1'b1, 1'b0);
        bus.Stop = 1'b1;
        #1;
        tick();
        check_step("stop add T5", M_ZLOWOUT, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b0);
        tick();
        check_step("stop halt", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        check("stop count", 32'(bus.instr_count), 32'd5);
        bus.Stop = 1'b0;
        tick();
        tick();
        check_step("stop halt held", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        check("stop halt count", 32'(bus.instr_count), 32'd5);

        // Clear out of HALT
        clear = 1'b1;
        tick();
        check("clear count", 32'(bus.instr_count), 32'd0);
        clear = 1'b0;
        #1;
        check_step("clear idle", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // mul aborted by Clear in T4
        tick();
        bus.IR = I_MUL;
        #1;
        fetch("abort mul");
        tick();
        tick();
        check_step("abort mul T4", M_ZLOWIN | M_ZHIGHIN, 16'h0, 16'h0008, 5'b00110, 1'b1, 1'b0);
        clear = 1'b1;
        #1;
        check("abort LOin", 32'(bus.LOin), 32'd0);
        check("abort HIin", 32'(bus.HIin), 32'd0);
        tick();
        check_step("abort idle", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        check("abort count", 32'(bus.instr_count), 32'd0);
        clear = 1'b0;
        #1;
        check_step("abort idle released", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // nop with a Stop pulse that drops before retire
        tick();
        bus.IR   = I_NOP;
        bus.Stop = 1'b1;
        #1;
        fetch("nop");
        bus.Stop = 1'b0;
        #1;
        tick();
        check_step("nop T3", 15'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick();
        check("nop count", 32'(bus.instr_count), 32'd1);

        // halt instruction
        bus.IR = I_HALT;
        #1;
        fetch("halt");
        tick();
        check_step("halt T3", 15'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        tick();
        check_step("halt state", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        check("halt count", 32'(bus.instr_count), 32'd1);
        tick();
        tick();
        tick();
        check_step("halt held", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        check("halt held count", 32'(bus.instr_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
